// File: rtl/ahfp_f2x_sched.sv
// Round-robin scheduler sharing one float-to-fixed converter between NUM_REQ requesters.
// Define AHFP_F2X_SCHED_STATS_EN to add the conv_count / stall_count statistics ports.
module ahfp_f2x_sched #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = 2,
    parameter int unsigned DATA_W  = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [DATA_W-1:0]         f2x_in,
    input  logic [DATA_W-1:0]         f2x_out,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [DATA_W-1:0]         rsp_data,
    output logic [ID_W-1:0]           rsp_id
`ifdef AHFP_F2X_SCHED_STATS_EN
    ,
    output logic [31:0]               conv_count,
    output logic [31:0]               stall_count
`endif
);

    // S1: operand stage feeding the converter
    logic [DATA_W-1:0] op_q, op_d;
    logic [ID_W-1:0]   op_id_q, op_id_d;
    logic              op_vld_q, op_vld_d;

    // S2: response stage
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
    logic              rsp_valid_q, rsp_valid_d;

    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;

    logic              s2_free;
    logic              s1_adv;
    logic              s1_accept;

    logic [NUM_REQ-1:0] grant;
    logic               grant_vld;
    logic [ID_W-1:0]    grant_id;
    logic [ID_W-1:0]    grant_nxt;
    logic [DATA_W-1:0]  grant_data;

    assign s2_free   = !rsp_valid_q || rsp_ready;
    assign s1_adv    = s2_free;
    assign s1_accept = !op_vld_q || s1_adv;

    // Two passes: first requesters at or above rr_ptr, then the wrapped-around lower ones.
    always_comb begin
        grant      = '0;
        grant_vld  = 1'b0;
        grant_id   = '0;
        grant_nxt  = '0;
        grant_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!grant_vld && req_valid[i] && (i >= int'(rr_ptr_q))) begin
                grant_vld  = 1'b1;
                grant[i]   = 1'b1;
                grant_id   = ID_W'(i);
                grant_nxt  = ID_W'((i + 1) % NUM_REQ);
                grant_data = req_data[i*DATA_W +: DATA_W];
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!grant_vld && req_valid[i]) begin
                grant_vld  = 1'b1;
                grant[i]   = 1'b1;
                grant_id   = ID_W'(i);
                grant_nxt  = ID_W'((i + 1) % NUM_REQ);
                grant_data = req_data[i*DATA_W +: DATA_W];
            end
        end
        if (!s1_accept || reset) begin
            grant     = '0;
            grant_vld = 1'b0;
        end
    end

    assign req_ready = grant;

    always_comb begin
        op_d        = op_q;
        op_id_d     = op_id_q;
        op_vld_d    = op_vld_q;
        rr_ptr_d    = rr_ptr_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_id_d    = rsp_id_q;

        if (grant_vld) begin
            op_d     = grant_data;
            op_id_d  = grant_id;
            op_vld_d = 1'b1;
            rr_ptr_d = grant_nxt;
        end else if (s1_adv) begin
            op_vld_d = 1'b0;
        end

        if (s1_adv) begin
            rsp_valid_d = op_vld_q;
            rsp_data_d  = f2x_out;
            rsp_id_d    = op_id_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_q        <= '0;
            op_id_q     <= '0;
            op_vld_q    <= 1'b0;
            rr_ptr_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_id_q    <= '0;
        end else begin
            op_q        <= op_d;
            op_id_q     <= op_id_d;
            op_vld_q    <= op_vld_d;
            rr_ptr_q    <= rr_ptr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_id_q    <= rsp_id_d;
        end
    end

    assign f2x_in    = op_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_id    = rsp_id_q;

`ifdef AHFP_F2X_SCHED_STATS_EN
    logic [31:0] conv_q;
    logic [31:0] stall_q;

    // conv_count wraps naturally; stall_count sticks at all-ones.
    always_ff @(posedge clk) begin
        if (reset) begin
            conv_q  <= '0;
            stall_q <= '0;
        end else begin
            if (rsp_valid_q && rsp_ready) begin
                conv_q <= conv_q + 32'd1;
            end
            if (rsp_valid_q && !rsp_ready && (stall_q != 32'hFFFF_FFFF)) begin
                stall_q <= stall_q + 32'd1;
            end
        end
    end

    assign conv_count  = conv_q;
    assign stall_count = stall_q;
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_ahfp_f2x_sched.sv
// Bench for ahfp_f2x_sched: FIFO/round-robin reference model checked every cycle, plus
// directed scenarios with literal expectations.
module tb_ahfp_f2x_sched;

    localparam int N = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [N-1:0]  req_valid = '0;
    logic [N-1:0]  req_ready;
    logic [N*32-1:0] req_data = '0;
    logic [31:0]   f2x_in;
    logic [31:0]   f2x_out;
    logic          rsp_valid;
    logic          rsp_ready = 1'b1;
    logic [31:0]   rsp_data;
    logic [1:0]    rsp_id;
`ifdef AHFP_F2X_SCHED_STATS_EN
    logic [31:0]   conv_count;
    logic [31:0]   stall_count;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    ahfp_f2x_sched #(
        .NUM_REQ (N),
        .ID_W    (2),
        .DATA_W  (32)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data  (req_data),
        .f2x_in    (f2x_in),
        .f2x_out   (f2x_out),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id)
`ifdef AHFP_F2X_SCHED_STATS_EN
        ,
        .conv_count  (conv_count),
        .stall_count (stall_count)
`endif
    );

    // Behavioural stand-in for the converter: IEEE single -> signed Q3.29.
    function automatic logic [31:0] f2x(input logic [31:0] f);
        int          sh;
        logic [31:0] mant;
        logic [31:0] mag;
        mant = {8'd0, 1'b1, f[22:0]};
        sh   = int'(f[30:23]) - 121;
        if (f[30:23] == 8'd0)  mag = 32'd0;
        else if (sh >= 8)      mag = 32'h7FFF_FFFF;
        else if (sh >= 0)      mag = mant << sh;
        else if (sh > -32)     mag = mant >> (-sh);
        else                   mag = 32'd0;
        return f[31] ? (~mag + 32'd1) : mag;
    endfunction

    assign f2x_out = f2x(f2x_in);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [31:0] v);
        req_data[i*32 +: 32] = v;
    endtask

    // Reference model: an in-order queue of at most two operands, each visible one edge
    // after its accept, with round-robin grant order.
    typedef struct {
        logic [31:0] data;
        int          id;
        int          stamp;
    } item_t;

    item_t       q[$];
    item_t       p_item;
    int          ptr = 0;
    int          edge_cnt = 0;
    bit          p_pop = 0;
    bit          p_push = 0;
    bit          p_stall = 0;
    logic [31:0] m_conv = 0;
    logic [31:0] m_stall = 0;

    initial begin : model
        bit          exp_valid;
        bit          eligible;
        int          gid;
        logic [N-1:0] exp_gnt;
        forever begin
            @(posedge clk);
            edge_cnt++;
            if (reset) begin
                q.delete();
                ptr     = 0;
                m_conv  = 0;
                m_stall = 0;
            end else begin
                if (p_pop) begin
                    void'(q.pop_front());
                    m_conv = m_conv + 1;
                end
                if (p_stall && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
                if (p_push) begin
                    p_item.stamp = edge_cnt;
                    q.push_back(p_item);
                    ptr = (p_item.id + 1) % N;
                end
            end
            p_pop   = 0;
            p_push  = 0;
            p_stall = 0;

            @(negedge clk);
            exp_valid = 0;
            if (q.size() > 0) begin
                if (q[0].stamp < edge_cnt) exp_valid = 1;
            end
            chk("model_rsp_valid", {31'd0, rsp_valid}, {31'd0, exp_valid});
            if (exp_valid) begin
                chk("model_rsp_data", rsp_data, q[0].data);
                chk("model_rsp_id", {30'd0, rsp_id}, q[0].id);
            end
            eligible = !reset && (q.size() < 2 || rsp_ready);
            gid = -1;
            exp_gnt = '0;
            if (eligible) begin
                for (int k = 0; k < N; k++) begin
                    if (gid < 0 && req_valid[(ptr + k) % N]) gid = (ptr + k) % N;
                end
            end
            if (gid >= 0) exp_gnt[gid] = 1'b1;
            chk("model_req_ready", {28'd0, req_ready}, {28'd0, exp_gnt});
`ifdef AHFP_F2X_SCHED_STATS_EN
            chk("model_conv_count", conv_count, m_conv);
            chk("model_stall_count", stall_count, m_stall);
`endif
            p_pop   = exp_valid && rsp_ready;
            p_stall = exp_valid && !rsp_ready;
            if (gid >= 0) begin
                p_push      = 1;
                p_item.data = f2x(req_data[gid*32 +: 32]);
                p_item.id   = gid;
            end
        end
    end

    logic [31:0] ops[4] = '{32'h3F80_0000, 32'h3F00_0000, 32'h3E80_0000, 32'h4000_0000};
    logic [31:0] res[4] = '{32'h2000_0000, 32'h1000_0000, 32'h0800_0000, 32'h4000_0000};

    initial begin : stim
        int acc;
        chk("pin_f2x_two", f2x(ops[3]), res[3]);
        chk("pin_f2x_quarter", f2x(ops[2]), res[2]);

        // Reset with every requester asking: nothing may be granted.
        req_valid = 4'hF;
        repeat (3) step();
        @(negedge clk);
        chk("reset_req_ready", {28'd0, req_ready}, 32'd0);
        chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("reset_f2x_in", f2x_in, 32'd0);
        chk("reset_rsp_data", rsp_data, 32'd0);
        step();
        reset = 1'b0;
        req_valid = '0;

        // Single operand latency.
        step();
        set_op(0, 32'h3F80_0000);
        req_valid = 4'b0001;
        @(negedge clk);
        chk("t1_grant", {28'd0, req_ready}, 32'h1);
        step();
        req_valid = '0;
        @(negedge clk);
        chk("t1_not_yet", {31'd0, rsp_valid}, 32'd0);
        step();
        @(negedge clk);
        chk("t1_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("t1_rsp_data", rsp_data, 32'h2000_0000);
        chk("t1_rsp_id", {30'd0, rsp_id}, 32'd0);

        // All four valid: strict rotation and back-to-back results.
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) set_op(i, ops[i]);
        req_valid = 4'hF;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (k < 6) chk("rot_grant", {28'd0, req_ready}, 32'd1 << (k % 4));
            if (k >= 2) begin
                chk("rot_valid", {31'd0, rsp_valid}, 32'd1);
                chk("rot_data", rsp_data, res[(k - 2) % 4]);
                chk("rot_id", {30'd0, rsp_id}, (k - 2) % 4);
            end
            step();
        end
        req_valid = '0;
        repeat (3) step();

        // Stall: exactly two operands held, output stable, then drained in order.
        reset = 1'b1;
        step();
        reset = 1'b0;
        rsp_ready = 1'b0;
        req_valid = 4'b0110;
        acc = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (req_ready != '0) acc++;
            if (c >= 2) begin
                chk("stall_valid", {31'd0, rsp_valid}, 32'd1);
                chk("stall_id", {30'd0, rsp_id}, 32'd1);
                chk("stall_data", rsp_data, 32'h1000_0000);
            end
            if (c == 4) chk("stall_no_ready", {28'd0, req_ready}, 32'd0);
            step();
        end
        chk("stall_accepts", acc, 32'd2);
        rsp_ready = 1'b1;
        req_valid = '0;
        @(negedge clk);
        chk("drain_id1", {30'd0, rsp_id}, 32'd1);
        chk("drain_data1", rsp_data, 32'h1000_0000);
        step();
        @(negedge clk);
        chk("drain_valid2", {31'd0, rsp_valid}, 32'd1);
        chk("drain_id2", {30'd0, rsp_id}, 32'd2);
        chk("drain_data2", rsp_data, 32'h0800_0000);
        step();
        @(negedge clk);
        chk("drain_empty", {31'd0, rsp_valid}, 32'd0);

        // Pointer behaviour: 1, then 3 alone, then search restarts at 0.
        step();
        req_valid = 4'b0010;
        @(negedge clk);
        chk("ptr_grant1", {28'd0, req_ready}, 32'b0010);
        step();
        req_valid = 4'b1000;
        @(negedge clk);
        chk("ptr_grant3", {28'd0, req_ready}, 32'b1000);
        step();
        req_valid = 4'hF;
        @(negedge clk);
        chk("ptr_wrap0", {28'd0, req_ready}, 32'b0001);
        step();
        req_valid = 4'b0100;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("single_req", {28'd0, req_ready}, 32'b0100);
            step();
        end
        req_valid = '0;
        repeat (3) step();

        // Reset while both stages are full.
        rsp_ready = 1'b0;
        req_valid = 4'b0011;
        repeat (3) step();
        @(negedge clk);
        chk("full_before_reset", {31'd0, rsp_valid}, 32'd1);
        step();
        reset = 1'b1;
        req_valid = 4'hF;
        @(negedge clk);
        chk("in_reset_ready", {28'd0, req_ready}, 32'd0);
        step();
        @(negedge clk);
        chk("flush_valid", {31'd0, rsp_valid}, 32'd0);
        chk("flush_ready", {28'd0, req_ready}, 32'd0);
        step();
        reset = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("post_reset_grant", {28'd0, req_ready}, 32'b0001);
        step();
        req_valid = '0;
        repeat (3) step();

`ifdef AHFP_F2X_SCHED_STATS_EN
        reset = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clk);
        chk("stats_reset_conv", conv_count, 32'd0);
        chk("stats_reset_stall", stall_count, 32'd0);
        set_op(0, 32'h3F80_0000);
        req_valid = 4'b0001;
        repeat (10) step();
        req_valid = '0;
        rsp_ready = 1'b0;
        repeat (3) step();
        rsp_ready = 1'b1;
        repeat (4) step();
        @(negedge clk);
        chk("stats_conv", conv_count, 32'd10);
        chk("stats_stall", stall_count, 32'd3);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clk);
        chk("stats_clear_conv", conv_count, 32'd0);
        chk("stats_clear_stall", stall_count, 32'd0);
`endif

        repeat (2) step();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
